// File: rtl/contador_regressivo.sv
// N-bit synchronous down counter with load, cascade enables (ent/enp), ripple
// borrow out, optional auto-reload from the last loaded value, and a registered underflow pulse.
module contador_regressivo #(
    parameter int N   = 4,
    parameter int MAX = 15
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         ld,
    input  logic         ent,
    input  logic         enp,
    input  logic         auto,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic         rbo,
    output logic         zero,
    output logic         fim
);

    localparam logic [N-1:0] MAX_V = N'(MAX);

    logic [N-1:0] r_q;
    logic [N-1:0] r_reload;
    logic         r_fim;
    logic         w_zero;
    logic         w_count;
    logic [N-1:0] w_wrap;

    assign w_zero  = (r_q == {N{1'b0}});
    assign w_count = ent & enp;
    assign w_wrap  = auto ? r_reload : MAX_V;

    // Count state: load has priority over counting; underflow wraps and pulses fim.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            r_q      <= {N{1'b0}};
            r_reload <= MAX_V;
            r_fim    <= 1'b0;
        end else if (!ld) begin
            r_q      <= D;
            r_reload <= D;
            r_fim    <= 1'b0;
        end else if (w_count) begin
            if (w_zero) begin
                r_q   <= w_wrap;
                r_fim <= 1'b1;
            end else begin
                r_q   <= r_q - N'(1);
                r_fim <= 1'b0;
            end
        end else begin
            r_fim <= 1'b0;
        end
    end

    // Borrow is gated only by ent so a chain of stages ripples through ent.
    assign Q    = r_q;
    assign zero = w_zero;
    assign rbo  = ent & w_zero;
    assign fim  = r_fim;

endmodule

// File: tb/tb_contador_regressivo.sv
// Directed self-checking bench for contador_regressivo: single instance plus a
// two-stage cascade built from rbo -> ent.
module tb_contador_regressivo;

    logic       clk;
    logic       clr;
    logic       ld, ent, enp, auto_s;
    logic [3:0] d;
    logic [3:0] q;
    logic       rbo, zero, fim;

    logic       c_ld;
    logic [3:0] c_d_lo, c_d_hi;
    logic [3:0] c_q_lo, c_q_hi;
    logic       c_rbo_lo, c_rbo_hi, c_zero_lo, c_zero_hi, c_fim_lo, c_fim_hi;
    logic       c_en, c_auto;

    int checks;
    int failures;

    contador_regressivo #(.N(4), .MAX(15)) u_dut (
        .clock(clk), .clr(clr), .ld(ld), .ent(ent), .enp(enp), .auto(auto_s),
        .D(d), .Q(q), .rbo(rbo), .zero(zero), .fim(fim)
    );

    contador_regressivo #(.N(4), .MAX(15)) u_lo (
        .clock(clk), .clr(clr), .ld(c_ld), .ent(c_en), .enp(c_en), .auto(c_auto),
        .D(c_d_lo), .Q(c_q_lo), .rbo(c_rbo_lo), .zero(c_zero_lo), .fim(c_fim_lo)
    );

    contador_regressivo #(.N(4), .MAX(15)) u_hi (
        .clock(clk), .clr(clr), .ld(c_ld), .ent(c_rbo_lo), .enp(c_en), .auto(c_auto),
        .D(c_d_hi), .Q(c_q_hi), .rbo(c_rbo_hi), .zero(c_zero_hi), .fim(c_fim_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if (q !== 4'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q); end
        checks++;
        if (fim !== 1'b0) begin failures++; $display("FAIL reset_fim got=%0b exp=0", fim); end
        checks++;
        if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%0b exp=1", zero); end
        checks++;
        clr = 1'b1;
    endtask

    task automatic test_async_clear();
        ld = 1'b0; d = 4'd9; ent = 1'b0; enp = 1'b0; auto_s = 1'b1;
        tick();
        ld = 1'b1;
        tick();
        if (q !== 4'd9) begin failures++; $display("FAIL clr_pre_q got=%0d exp=9", q); end
        checks++;
        clr = 1'b0;
        #2;
        if (q !== 4'd0) begin failures++; $display("FAIL clr_async_q got=%0d exp=0", q); end
        checks++;
        if (fim !== 1'b0) begin failures++; $display("FAIL clr_async_fim got=%0b exp=0", fim); end
        checks++;
        clr = 1'b1;
        ent = 1'b1; enp = 1'b1;
        tick();
        if (q !== 4'd15 || fim !== 1'b1) begin
            failures++; $display("FAIL clr_first_edge got q=%0d fim=%0b exp q=15 fim=1", q, fim);
        end
        checks++;
        for (int i = 0; i < 15; i++) tick();
        if (q !== 4'd0 || fim !== 1'b0) begin
            failures++; $display("FAIL clr_countdown got q=%0d fim=%0b exp q=0 fim=0", q, fim);
        end
        checks++;
        tick();
        if (q !== 4'd15 || fim !== 1'b1) begin
            failures++; $display("FAIL clr_reload_max got q=%0d fim=%0b exp q=15 fim=1", q, fim);
        end
        checks++;
    endtask

    task automatic test_count_wrap();
        logic [27:0] eq;
        logic [6:0]  ef;
        logic [6:0]  er;
        eq = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
        ef = 7'b0000010;
        er = 7'b0000100;
        ld = 1'b0; d = 4'd5; ent = 1'b0; enp = 1'b0; auto_s = 1'b0;
        tick();
        ld = 1'b1; ent = 1'b1; enp = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (q !== eq[4*(6-i) +: 4]) begin
                failures++; $display("FAIL wrap_q[%0d] got=%0d exp=%0d", i, q, eq[4*(6-i) +: 4]);
            end
            checks++;
            if (fim !== ef[6-i]) begin
                failures++; $display("FAIL wrap_fim[%0d] got=%0b exp=%0b", i, fim, ef[6-i]);
            end
            checks++;
            if (rbo !== er[6-i] || zero !== er[6-i]) begin
                failures++; $display("FAIL wrap_rbo[%0d] got rbo=%0b zero=%0b exp=%0b", i, rbo, zero, er[6-i]);
            end
            checks++;
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] eq;
        logic [7:0]  ef;
        eq = {4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
        ef = 8'b00010001;
        ld = 1'b0; d = 4'd3; auto_s = 1'b1;
        tick();
        ld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (q !== eq[4*(7-i) +: 4] || fim !== ef[7-i]) begin
                failures++;
                $display("FAIL auto[%0d] got q=%0d fim=%0b exp q=%0d fim=%0b", i, q, fim, eq[4*(7-i) +: 4], ef[7-i]);
            end
            checks++;
        end
    endtask

    task automatic test_enables();
        ld = 1'b0; d = 4'd0; ent = 1'b1; enp = 1'b1; auto_s = 1'b0;
        tick();
        ld = 1'b1; enp = 1'b0;
        #1;
        if (rbo !== 1'b1) begin failures++; $display("FAIL en_rbo_ent1 got=%0b exp=1", rbo); end
        checks++;
        tick();
        if (q !== 4'd0 || fim !== 1'b0) begin
            failures++; $display("FAIL en_hold got q=%0d fim=%0b exp q=0 fim=0", q, fim);
        end
        checks++;
        ent = 1'b0;
        #1;
        if (rbo !== 1'b0 || zero !== 1'b1) begin
            failures++; $display("FAIL en_rbo_ent0 got rbo=%0b zero=%0b exp rbo=0 zero=1", rbo, zero);
        end
        checks++;
    endtask

    task automatic test_load_priority();
        ld = 1'b0; d = 4'd7; ent = 1'b1; enp = 1'b1; auto_s = 1'b0;
        tick();
        if (q !== 4'd7 || fim !== 1'b0) begin
            failures++; $display("FAIL load_wins got q=%0d fim=%0b exp q=7 fim=0", q, fim);
        end
        checks++;
        ld = 1'b1;
    endtask

    task automatic test_auto_zero_reload();
        ld = 1'b0; d = 4'd0; ent = 1'b1; enp = 1'b1; auto_s = 1'b1;
        tick();
        ld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (q !== 4'd0 || fim !== 1'b1) begin
                failures++; $display("FAIL auto_r0[%0d] got q=%0d fim=%0b exp q=0 fim=1", i, q, fim);
            end
            checks++;
        end
        ent = 1'b0; enp = 1'b0;
    endtask

    task automatic test_cascade();
        c_ld = 1'b0; c_d_lo = 4'h0; c_d_hi = 4'h1; c_en = 1'b1; c_auto = 1'b0;
        tick();
        if ({c_q_hi, c_q_lo} !== 8'h10) begin
            failures++; $display("FAIL casc_load got=%02h exp=10", {c_q_hi, c_q_lo});
        end
        checks++;
        c_ld = 1'b1;
        tick();
        if ({c_q_hi, c_q_lo} !== 8'h0F) begin
            failures++; $display("FAIL casc_first got=%02h exp=0f", {c_q_hi, c_q_lo});
        end
        checks++;
        for (int i = 0; i < 15; i++) tick();
        if ({c_q_hi, c_q_lo} !== 8'h00 || c_fim_hi !== 1'b0) begin
            failures++; $display("FAIL casc_zero got=%02h fim_hi=%0b exp=00 fim_hi=0", {c_q_hi, c_q_lo}, c_fim_hi);
        end
        checks++;
        tick();
        if ({c_q_hi, c_q_lo} !== 8'hFF || c_fim_hi !== 1'b1) begin
            failures++; $display("FAIL casc_wrap got=%02h fim_hi=%0b exp=ff fim_hi=1", {c_q_hi, c_q_lo}, c_fim_hi);
        end
        checks++;
        tick();
        if ({c_q_hi, c_q_lo} !== 8'hFE || c_fim_hi !== 1'b0) begin
            failures++; $display("FAIL casc_after got=%02h fim_hi=%0b exp=fe fim_hi=0", {c_q_hi, c_q_lo}, c_fim_hi);
        end
        checks++;
    endtask

    initial begin
        checks = 0; failures = 0;
        clr = 1'b0; ld = 1'b1; ent = 1'b0; enp = 1'b0; auto_s = 1'b0; d = 4'd0;
        c_ld = 1'b1; c_d_lo = 4'd0; c_d_hi = 4'd0; c_en = 1'b0; c_auto = 1'b0;
        #12;
        test_reset();
        test_async_clear();
        test_count_wrap();
        test_auto_reload();
        test_enables();
        test_load_priority();
        test_auto_zero_reload();
        test_cascade();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
